// File: rtl/ram_helper_arbiter.sv
// ram_helper_arbiter: round-robin sharing of one RAMHelper memory between N_REQ requesters
module ram_helper_arbiter #(
  parameter int          N_REQ    = 2,
  parameter logic [63:0] RAM_BASE = 64'h8000_0000,
  parameter logic [63:0] RAM_SIZE = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [64*N_REQ-1:0]   req_addr,
  input  logic [N_REQ-1:0]      req_wen,
  input  logic [64*N_REQ-1:0]   req_wdata,
  input  logic [64*N_REQ-1:0]   req_wmask,
  output logic [N_REQ-1:0]      resp_valid,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic [63:0]           resp_rdata,
  output logic                  resp_err,
  output logic [63:0]           ram_rIdx,
  input  logic [63:0]           ram_rdata,
  output logic [63:0]           ram_wIdx,
  output logic [63:0]           ram_wdata,
  output logic [63:0]           ram_wmask,
  output logic                  ram_wen
);
  localparam int W = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic [W-1:0] rr_ptr, owner, win;
  logic [W:0] sum;
  logic [2*N_REQ-1:0] dbl;
  logic found, sel_wen, sel_in_range, wen_q, in_range_q, err_q, req_fire, resp_fire;
  logic [63:0] sel_addr, sel_wdata, sel_wmask, off, idx_q, wdata_q, wmask_q, rdata_q;
  // first valid requester at or after rr_ptr; the lowest rotated position wins
  always_comb begin
    found = 1'b0;
    win = '0;
    sum = '0;
    dbl = {req_valid, req_valid} >> rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (W+1)'(k);
      if (dbl[k]) begin
        found = 1'b1;
        win = (sum >= (W+1)'(N_REQ)) ? W'(sum - (W+1)'(N_REQ)) : W'(sum);
      end
    end
  end
  // select the winner's request fields
  always_comb begin
    sel_addr = '0;
    sel_wen = 1'b0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == W'(k)) begin
        sel_addr = req_addr[k*64 +: 64];
        sel_wen = req_wen[k];
        sel_wdata = req_wdata[k*64 +: 64];
        sel_wmask = req_wmask[k*64 +: 64];
      end
    end
  end
  assign off = sel_addr - RAM_BASE;
  assign sel_in_range = (sel_addr >= RAM_BASE) && (off < RAM_SIZE);
  assign req_fire = (state == IDLE) && found;
  assign resp_fire = (state == RESP) && resp_ready[owner];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: ACCESS always lasts one cycle, RESP waits for the owner's ready
  always_comb
    state_nxt = (state == IDLE) ? (found ? ACCESS : IDLE) :
                (state == ACCESS) ? RESP : (resp_fire ? IDLE : RESP);
  // state-decoded outputs, so everything drops at once on async reset
  always_comb begin
    req_ready = (state == IDLE && found) ? N_REQ'(1) << win : '0;
    resp_valid = (state == RESP) ? N_REQ'(1) << owner : '0;
    resp_rdata = (state == RESP) ? rdata_q : '0;
    resp_err = (state == RESP) && err_q;
    ram_wen = (state == ACCESS) && wen_q && in_range_q;
  end
  assign ram_rIdx = idx_q;
  assign ram_wIdx = idx_q;
  assign ram_wdata = wdata_q;
  assign ram_wmask = wmask_q;
  // capture on accept, sample RAM during ACCESS, advance pointer on response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr <= '0;
      owner <= '0;
      wen_q <= 1'b0;
      in_range_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (req_fire) begin
        owner <= win;
        wen_q <= sel_wen;
        in_range_q <= sel_in_range;
        idx_q <= off >> 3;
        wdata_q <= sel_wdata;
        wmask_q <= sel_wmask;
      end
      if (state == ACCESS) begin
        rdata_q <= (!wen_q && in_range_q) ? ram_rdata : '0;
        err_q <= !in_range_q;
      end
      if (resp_fire) rr_ptr <= (owner == W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    end
endmodule

// File: tb/tb_ram_helper_arbiter.sv
// tb_ram_helper_arbiter: directed and random checks of ram_helper_arbiter against a transaction model
module tb_ram_helper_arbiter;
  localparam int N = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h8000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, req_wen, resp_valid, resp_ready;
  logic [64*N-1:0] req_addr, req_wdata, req_wmask;
  logic [63:0] resp_rdata, ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;
  logic resp_err, ram_wen;
  logic [63:0] ram_mem [64];
  logic pl_en = 1'b0;
  logic [5:0] pl_idx = '0;
  logic [63:0] pl_val = '0;
  logic [63:0] ref_mem [64];
  logic p_valid [N];
  logic [63:0] p_addr [N];
  logic p_wen [N];
  logic [63:0] p_wdata [N];
  logic [63:0] p_wmask [N];
  int ref_rr = 0;
  int checks = 0;
  int errors = 0;
  logic [63:0] keep;

  ram_helper_arbiter #(.N_REQ(N), .RAM_BASE(BASE), .RAM_SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata), .ram_wIdx(ram_wIdx), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  always #5 clk = ~clk;

  assign ram_rdata = ram_mem[ram_rIdx[5:0]];
  always @(posedge clk)
    if (pl_en) ram_mem[pl_idx] <= pl_val;
    else if (ram_wen) ram_mem[ram_wIdx[5:0]] <= (ram_mem[ram_wIdx[5:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = p_valid[i];
      req_addr[i*64 +: 64] = p_addr[i];
      req_wen[i] = p_wen[i];
      req_wdata[i*64 +: 64] = p_wdata[i];
      req_wmask[i*64 +: 64] = p_wmask[i];
    end
  endtask

  task automatic set_req(input int p, input logic [63:0] a, input logic w, input logic [63:0] d, input logic [63:0] m);
    p_valid[p] = 1'b1;
    p_addr[p] = a;
    p_wen[p] = w;
    p_wdata[p] = d;
    p_wmask[p] = m;
  endtask

  task automatic preload(input int i, input logic [63:0] v);
    pl_en = 1'b1;
    pl_idx = 6'(i);
    pl_val = v;
    ref_mem[i] = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    resp_ready = '0;
    for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    drive();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_rr = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic any_pending();
    logic r = 1'b0;
    for (int i = 0; i < N; i++) r |= p_valid[i];
    return r;
  endfunction

  function automatic logic [63:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k < 8) return BASE + 64'($urandom_range(0, 63)) * 8 + 64'($urandom_range(0, 7));
    if (k == 8) return 64'($urandom_range(0, 32'h7FFF_FFFF));
    return BASE + SIZE + 64'($urandom);
  endfunction

  task automatic serve_one(input int hold);
    int w = -1;
    logic [63:0] a, idx, exp_rd;
    logic inr, we;
    for (int k = N - 1; k >= 0; k--) if (p_valid[(ref_rr + k) % N]) w = (ref_rr + k) % N;
    if (w < 0) return;
    drive(); #1;
    chk("grant", 64'(req_ready), 64'(1) << w);
    a = p_addr[w];
    we = p_wen[w];
    inr = (a >= BASE) && (a - BASE < SIZE);
    idx = (a - BASE) >> 3;
    exp_rd = (!we && inr) ? ref_mem[idx[5:0]] : 64'h0;
    @(posedge clk); #1;
    p_valid[w] = 1'b0;
    drive();
    chk("access_wen", 64'(ram_wen), 64'(we && inr));
    chk("access_ready", 64'(req_ready), 64'h0);
    if (inr) begin
      chk("access_widx", ram_wIdx, idx);
      chk("access_ridx", ram_rIdx, idx);
    end
    if (we && inr) begin
      chk("access_wdata", ram_wdata, p_wdata[w]);
      chk("access_wmask", ram_wmask, p_wmask[w]);
      ref_mem[idx[5:0]] = (ref_mem[idx[5:0]] & ~p_wmask[w]) | (p_wdata[w] & p_wmask[w]);
    end
    @(posedge clk); #1;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", 64'(resp_valid), 64'(1) << w);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err", 64'(resp_err), 64'(!inr));
      chk("resp_blocks_req", 64'(req_ready), 64'h0);
      chk("resp_no_wen", 64'(ram_wen), 64'h0);
      if (h < hold) begin @(posedge clk); #1; end
    end
    resp_ready[w] = 1'b1;
    @(posedge clk); #1;
    resp_ready = '0;
    chk("resp_done", 64'(resp_valid), 64'h0);
    ref_rr = (w + 1) % N;
  endtask

  initial begin
    resp_ready = '0;
    for (int i = 0; i < N; i++) set_req(i, 64'h0, 1'b0, 64'h0, 64'h0);
    for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    drive();
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) preload(i, {$urandom, $urandom});
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_rdata", resp_rdata, 64'h0);
    chk("rst_resp_err", 64'(resp_err), 64'h0);
    chk("rst_ram_wen", 64'(ram_wen), 64'h0);
    chk("rst_ram_ridx", ram_rIdx, 64'h0);
    chk("rst_ram_widx", ram_wIdx, 64'h0);
    chk("rst_ram_wdata", ram_wdata, 64'h0);
    chk("rst_ram_wmask", ram_wmask, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(0, BASE + 64'h10, 1'b1, 64'hDEAD_BEEF_0123_4567, '1);
    serve_one(0);
    set_req(0, BASE + 64'h10, 1'b0, 64'h0, 64'h0);
    serve_one(0);
    do_reset();
    for (int r = 0; r < 3; r++) begin
      set_req(0, rand_addr(), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      set_req(1, rand_addr(), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      serve_one(0);
      serve_one(0);
    end
    set_req(1, 64'h1000, 1'b1, 64'h1234_5678_9ABC_DEF0, '1);
    serve_one(0);
    set_req(1, BASE + SIZE, 1'b0, 64'h0, 64'h0);
    serve_one(0);
    set_req(1, BASE + SIZE - 8, 1'b0, 64'h0, 64'h0);
    serve_one(0);
    preload(0, '1);
    set_req(0, BASE, 1'b1, 64'h0, 64'h0000_0000_FFFF_FFFF);
    serve_one(0);
    set_req(0, BASE, 1'b0, 64'h0, 64'h0);
    serve_one(0);
    do_reset();
    set_req(0, BASE + 64'h40, 1'b0, 64'h0, 64'h0);
    set_req(1, BASE + 64'h48, 1'b0, 64'h0, 64'h0);
    serve_one(5);
    serve_one(0);
    keep = {$urandom, $urandom};
    preload(1, keep);
    set_req(0, BASE + 64'h8, 1'b1, ~keep, '1);
    drive(); #1;
    chk("mid_grant", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    chk("mid_access_wen", 64'(ram_wen), 64'h1);
    rst_n = 1'b0;
    p_valid[0] = 1'b0;
    drive(); #1;
    chk("mid_rst_wen", 64'(ram_wen), 64'h0);
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    chk("mid_rst_resp", 64'(resp_valid), 64'h0);
    @(posedge clk); #1;
    chk("mid_rst_noresp", 64'(resp_valid), 64'h0);
    rst_n = 1'b1;
    ref_rr = 0;
    @(posedge clk); #1;
    chk("mid_post_resp", 64'(resp_valid), 64'h0);
    set_req(0, BASE + 64'h8, 1'b0, 64'h0, 64'h0);
    serve_one(0);
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 1) == 1)
          set_req(p, rand_addr(), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      if (!any_pending()) set_req(it % N, rand_addr(), 1'b0, 64'h0, 64'h0);
      while (any_pending()) serve_one($urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
